full_adder_3_bit_to_4_bit: RTL and testbench
============================================

Name: full_adder_3_bit_to_4_bit

Overview:
- Unsigned 3-bit + 3-bit adder producing a full 4-bit result, so it never overflows.
- Built as a structural ripple-carry chain of three 1-bit full-adder cells.
- SUM is a purely combinational output, used directly by the neighbour-count logic of the Conway cell array.
- A registered copy of the sum, plus a carry-out flag, is also provided for pipelined consumers.

Parameters:
- None. All widths are fixed (inputs 3 bits, outputs 4 bits).

Ports:
- CLK    input   1  rising-edge clock; drives only the registered outputs
- RST    input   1  asynchronous, active-high reset; clears only the registered outputs
- A      input   3  unsigned addend
- B      input   3  unsigned addend
- SUM    output  4  combinational result, A + B (zero latency)
- CARRY  output  1  combinational carry-out, equal to SUM[3]
- SUM_Q  output  4  SUM registered on the rising edge of CLK
- CARRY_Q output 1  CARRY registered on the rising edge of CLK

Behaviour:
- Bit cell i (i = 0..2):
  - s[i] = A[i] ^ B[i] ^ c[i]
  - c[i+1] = (A[i] & B[i]) | (A[i] & c[i]) | (B[i] & c[i])
  - c[0] = 0
- Result assembly: SUM = {c[3], s[2], s[1], s[0]}; CARRY = c[3].
- Arithmetic: SUM equals the unsigned value A + B in the range 0..14. There is no truncation, wrap-around or saturation.
- Combinational path:
  - SUM and CARRY settle within the same delta/time step as any change on A or B.
  - No clock is required for them.
  - They are unaffected by CLK and RST, including while RST is asserted.
- No latches; no X-propagation beyond X on inputs. If any bit of A or B is X/Z, the affected SUM bits may be X.
- Registered path:
  - Rising edge of CLK with RST = 0: SUM_Q <= SUM, CARRY_Q <= CARRY. Latency is 1 cycle from a stable A/B to SUM_Q.
  - RST asserted (asynchronous, active-high): SUM_Q = 4'b0000 and CARRY_Q = 0 immediately, independent of CLK.
  - While RST is held, SUM_Q and CARRY_Q stay 0 across clock edges.
  - RST deasserted: the first rising CLK edge loads the current sum.
  - Reset mid-operation clears the registered outputs immediately; the combinational SUM continues to track A and B.
- Reset values: SUM_Q = 0, CARRY_Q = 0. SUM and CARRY have no reset value; they are always A + B.
- Boundary cases:
  - A = B = 0 gives SUM = 0000, CARRY = 0.
  - A = B = 7 gives SUM = 1110, CARRY = 1.
  - Carry ripples through all three cells: A = 7, B = 1 gives SUM = 1000.

Test Plan:
- Exhaustive combinational sweep: all 64 (A, B) pairs, B in the outer loop and A in the inner loop, one step apart. Check SUM == A + B after 1 time unit. Examples: (3, 2) -> 0101; (6, 7) -> 1101; (7, 7) -> 1110. Error count must be 0.
- Full carry ripple: A = 3'b111, B = 3'b001 -> SUM = 4'b1000, CARRY = 1. Then A = 3'b011, B = 3'b001 -> SUM = 4'b0100, CARRY = 0.
- Zero and commutativity: A = 0, B = 0 -> SUM = 0000. Then A = 5, B = 2 and A = 2, B = 5 -> both give SUM = 0111.
- Registered path: RST = 0, A = 6, B = 5, one rising CLK edge -> SUM_Q = 4'b1011, CARRY_Q = 1. Change A to 1 -> SUM = 0110 immediately, SUM_Q holds 1011 until the next edge, then becomes 0110.
- Async reset: with SUM_Q = 1011, assert RST between edges -> SUM_Q = 0000 and CARRY_Q = 0 immediately, while SUM still reads A + B. Hold RST over 2 edges -> outputs stay 0. Release RST; the next edge loads the current sum.

Source files
------------

// File: rtl/full_adder_3_bit_to_4_bit.sv
// Unsigned 3-bit + 3-bit ripple-carry adder with a full 4-bit result.
// Combinational SUM/CARRY feed the Conway neighbour count; SUM_Q/CARRY_Q are a registered copy.

module full_adder_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

module full_adder_3_bit_to_4_bit (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] A,
  input  logic [2:0] B,
  output logic [3:0] SUM,
  output logic       CARRY,
  output logic [3:0] SUM_Q,
  output logic       CARRY_Q
);

  logic [3:0] w_carry;
  logic [2:0] w_sum_bits;
  logic [3:0] r_sum;
  logic       r_carry;

  assign w_carry[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cell
      full_adder_cell u_cell (
        .i_a (A[gi]),
        .i_b (B[gi]),
        .i_c (w_carry[gi]),
        .o_s (w_sum_bits[gi]),
        .o_c (w_carry[gi+1])
      );
    end
  endgenerate

  // The final carry becomes the MSB, so the result never wraps.
  assign SUM   = {w_carry[3], w_sum_bits};
  assign CARRY = w_carry[3];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sum   <= 4'b0000;
      r_carry <= 1'b0;
    end else begin
      r_sum   <= SUM;
      r_carry <= CARRY;
    end
  end

  assign SUM_Q   = r_sum;
  assign CARRY_Q = r_carry;

endmodule

// File: tb/tb_full_adder_3_bit_to_4_bit.sv
// Directed-vector bench for full_adder_3_bit_to_4_bit: combinational sweep,
// carry ripple cases, registered path and asynchronous reset behaviour.

module tb_full_adder_3_bit_to_4_bit;

  logic       CLK;
  logic       RST;
  logic [2:0] A;
  logic [2:0] B;
  logic [3:0] SUM;
  logic       CARRY;
  logic [3:0] SUM_Q;
  logic       CARRY_Q;

  int n_vectors;
  int n_miscompares;

  full_adder_3_bit_to_4_bit dut (
    .CLK     (CLK),
    .RST     (RST),
    .A       (A),
    .B       (B),
    .SUM     (SUM),
    .CARRY   (CARRY),
    .SUM_Q   (SUM_Q),
    .CARRY_Q (CARRY_Q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vectors++;
    if (obs !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %b, expected %b", tag, obs, exp);
    end else begin
      $display("ok   %s: %b", tag, obs);
    end
  endtask

  // Directed vectors: a, b, expected sum (hand-computed)
  logic [2:0] dir_a   [8] = '{3'd7, 3'd3, 3'd0, 3'd5, 3'd2, 3'd3, 3'd6, 3'd7};
  logic [2:0] dir_b   [8] = '{3'd1, 3'd1, 3'd0, 3'd2, 3'd5, 3'd2, 3'd7, 3'd7};
  logic [3:0] dir_sum [8] = '{4'b1000, 4'b0100, 4'b0000, 4'b0111,
                              4'b0111, 4'b0101, 4'b1101, 4'b1110};

  initial begin
    n_vectors     = 0;
    n_miscompares = 0;
    RST = 1'b1;
    A   = 3'd0;
    B   = 3'd0;

    // Reset state, and combinational path live while reset is held
    #2;
    check_val("reset SUM_Q", SUM_Q, 4'b0000);
    check_val("reset CARRY_Q", {3'b000, CARRY_Q}, 4'b0000);
    A = 3'd3; B = 3'd4;
    #1;
    check_val("SUM under reset", SUM, 4'b0111);
    @(posedge CLK); #1;
    check_val("SUM_Q held in reset", SUM_Q, 4'b0000);

    // Exhaustive sweep, B outer, A inner
    for (int b = 0; b < 8; b++) begin
      for (int a = 0; a < 8; a++) begin
        A = a[2:0]; B = b[2:0];
        #1;
        check_val($sformatf("sweep %0d+%0d SUM", a, b), SUM, 4'(a + b));
        check_val($sformatf("sweep %0d+%0d CARRY", a, b), {3'b000, CARRY},
                  ((a + b) >= 8) ? 4'd1 : 4'd0);
      end
    end

    // Directed ripple, zero, commutativity and boundary vectors
    for (int i = 0; i < 8; i++) begin
      A = dir_a[i]; B = dir_b[i];
      #1;
      check_val($sformatf("dir %0d+%0d SUM", dir_a[i], dir_b[i]), SUM, dir_sum[i]);
      check_val($sformatf("dir %0d+%0d CARRY", dir_a[i], dir_b[i]), {3'b000, CARRY},
                {3'b000, dir_sum[i][3]});
    end

    // Registered path
    @(negedge CLK);
    RST = 1'b0;
    A = 3'd6; B = 3'd5;
    @(posedge CLK); #1;
    check_val("reg 6+5 SUM_Q", SUM_Q, 4'b1011);
    check_val("reg 6+5 CARRY_Q", {3'b000, CARRY_Q}, 4'b0001);
    A = 3'd1;
    #1;
    check_val("comb 1+5 SUM", SUM, 4'b0110);
    check_val("reg hold SUM_Q", SUM_Q, 4'b1011);
    @(posedge CLK); #1;
    check_val("reg 1+5 SUM_Q", SUM_Q, 4'b0110);
    check_val("reg 1+5 CARRY_Q", {3'b000, CARRY_Q}, 4'b0000);

    // Asynchronous reset between edges
    A = 3'd6;
    @(posedge CLK); #1;
    check_val("reg reload SUM_Q", SUM_Q, 4'b1011);
    #2;
    RST = 1'b1;
    #1;
    check_val("async rst SUM_Q", SUM_Q, 4'b0000);
    check_val("async rst CARRY_Q", {3'b000, CARRY_Q}, 4'b0000);
    check_val("async rst SUM live", SUM, 4'b1011);
    repeat (2) @(posedge CLK);
    #1;
    check_val("rst held SUM_Q", SUM_Q, 4'b0000);
    check_val("rst held CARRY_Q", {3'b000, CARRY_Q}, 4'b0000);
    @(negedge CLK);
    RST = 1'b0;
    A = 3'd7; B = 3'd7;
    #1;
    check_val("rst released SUM_Q", SUM_Q, 4'b0000);
    @(posedge CLK); #1;
    check_val("first edge SUM_Q", SUM_Q, 4'b1110);
    check_val("first edge CARRY_Q", {3'b000, CARRY_Q}, 4'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
